// File: rtl/pckt_frame_ctrl_if.sv
// Capture-sequencer bus: packet-handler stream, host control/status and frame-buffer write port.
interface pckt_frame_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned CNT_WIDTH  = 12
);
  logic                  frame_active;
  logic                  frame_valid;
  logic [DATA_WIDTH-1:0] pixel_data;
  logic [CNT_WIDTH-1:0]  cfg_lines;
  logic [CNT_WIDTH-1:0]  cfg_words;
  logic                  cap_req;
  logic                  cap_busy;
  logic                  cap_done;
  logic [2:0]            cap_err;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [CNT_WIDTH-1:0]  lines_rcvd;

  modport master (
    output frame_active, frame_valid, pixel_data, cfg_lines, cfg_words, cap_req,
    input  cap_busy, cap_done, cap_err, wr_en, wr_addr, wr_data, lines_rcvd
  );

  modport slave (
    input  frame_active, frame_valid, pixel_data, cfg_lines, cfg_words, cap_req,
    output cap_busy, cap_done, cap_err, wr_en, wr_addr, wr_data, lines_rcvd
  );
endinterface

// File: rtl/pckt_frame_ctrl.sv
// Frame capture sequencer: aligns to a whole CSI-2 frame and writes it linearly into a frame buffer.
// Optional PFC_CONTINUOUS_EN: re-arm after every frame until the host requests a stop.
module pckt_frame_ctrl #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned CNT_WIDTH  = 12
) (
  input  logic             rxbyteclkhs,
  input  logic             reset_n,
  pckt_frame_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SYNC, ARMED, CAPTURE} state_t;

  localparam logic [CNT_WIDTH-1:0]  CNT_MAX  = '1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

  state_t                state_q, state_d;
  logic                  fa_q, fv_q;
  logic [CNT_WIDTH-1:0]  cfg_lines_q, cfg_lines_d;
  logic [CNT_WIDTH-1:0]  cfg_words_q, cfg_words_d;
  logic [CNT_WIDTH-1:0]  lines_q, lines_d, lines_inc;
  logic [CNT_WIDTH-1:0]  words_q, words_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [2:0]            err_q, err_d;
  logic                  wr_en_q, wr_en_d;
  logic                  done_q, done_d;
  logic                  line_end, frame_end, frame_start;
`ifdef PFC_CONTINUOUS_EN
  logic                  stop_q, stop_d;
`endif

  // Edge detection against the previous sample of the packet-handler flags.
  assign line_end    = fv_q & ~bus.frame_valid;
  assign frame_end   = fa_q & ~bus.frame_active;
  assign frame_start = ~fa_q & bus.frame_active;
  assign lines_inc   = (lines_q == CNT_MAX) ? lines_q : lines_q + CNT_WIDTH'(1);

  always_ff @(posedge rxbyteclkhs) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    cfg_lines_d = cfg_lines_q;
    cfg_words_d = cfg_words_q;
    lines_d     = lines_q;
    words_d     = words_q;
    addr_d      = addr_q;
    err_d       = err_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    done_d      = 1'b0;
`ifdef PFC_CONTINUOUS_EN
    stop_d      = stop_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.cap_req) begin
          cfg_lines_d = bus.cfg_lines;
          cfg_words_d = bus.cfg_words;
          err_d       = '0;
          lines_d     = '0;
          addr_d      = '0;
          words_d     = '0;
`ifdef PFC_CONTINUOUS_EN
          stop_d      = 1'b0;
`endif
          state_d     = bus.frame_active ? SYNC : ARMED;
        end
      end

      SYNC: begin
        if (!bus.frame_active) state_d = ARMED;
      end

      ARMED: begin
`ifdef PFC_CONTINUOUS_EN
        // No frame in flight, so a stop request returns to IDLE at once.
        if (bus.cap_req) begin
          state_d = IDLE;
        end else if (frame_start) begin
          err_d   = '0;
          lines_d = '0;
          addr_d  = '0;
          words_d = '0;
          state_d = CAPTURE;
        end
`else
        if (frame_start) state_d = CAPTURE;
`endif
      end

      CAPTURE: begin
        if (bus.frame_valid) begin
          words_d = (words_q == CNT_MAX) ? words_q : words_q + CNT_WIDTH'(1);
          // After the last buffer word is written, the rest of the frame is dropped.
          if (!err_q[2]) begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = bus.pixel_data;
            if (addr_q == ADDR_MAX) err_d[2] = 1'b1;
            else                    addr_d   = addr_q + ADDR_WIDTH'(1);
          end
        end
        if (line_end) begin
          lines_d = lines_inc;
          words_d = '0;
          if (words_q != cfg_words_q) err_d[1] = 1'b1;
        end
        // Line close above is already folded into lines_d for the line-count check.
        if (frame_end) begin
          if (lines_d != cfg_lines_q) err_d[0] = 1'b1;
          done_d = 1'b1;
`ifdef PFC_CONTINUOUS_EN
          state_d = (stop_q || bus.cap_req) ? IDLE : ARMED;
          stop_d  = 1'b0;
        end else if (bus.cap_req) begin
          stop_d  = 1'b1;
`else
          state_d = IDLE;
`endif
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge rxbyteclkhs) begin
    if (!reset_n) begin
      fa_q        <= 1'b0;
      fv_q        <= 1'b0;
      cfg_lines_q <= '0;
      cfg_words_q <= '0;
      lines_q     <= '0;
      words_q     <= '0;
      addr_q      <= '0;
      err_q       <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      done_q      <= 1'b0;
`ifdef PFC_CONTINUOUS_EN
      stop_q      <= 1'b0;
`endif
    end else begin
      fa_q        <= bus.frame_active;
      fv_q        <= bus.frame_valid;
      cfg_lines_q <= cfg_lines_d;
      cfg_words_q <= cfg_words_d;
      lines_q     <= lines_d;
      words_q     <= words_d;
      addr_q      <= addr_d;
      err_q       <= err_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      done_q      <= done_d;
`ifdef PFC_CONTINUOUS_EN
      stop_q      <= stop_d;
`endif
    end
  end

  assign bus.cap_busy   = (state_q != IDLE);
  assign bus.cap_done   = done_q;
  assign bus.cap_err    = err_q;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.lines_rcvd = lines_q;

endmodule
